mlp_sequencer: RTL

- Cycle-level sequencer for the neural processor datapath.
- Runs one inference per sample:
  - fetches the sample and its label;
  - drives three hidden-layer passes of 10 processing units each;
  - drives one output-layer pass;
  - compares the result against the label, bumps the accuracy counter and advances the sample address.
- Sits beside datapath/data_mem/label_mem in neural_processor. It adds start/busy control and a programmable PU latency compared with the existing fixed controller.

---
 rtl/mlp_pkg.sv | 18 +
 rtl/mlp_sequencer_pass_timer.sv | 25 ++
 rtl/mlp_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP inference sequencer.
package mlp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    HID,
    OUT,
    CHECK,
    NEXT,
    DONE
  } state_t;

  localparam int         HID_PASSES   = 3;
  localparam int         PUS_PER_PASS = 10;
  localparam logic [1:0] OUT_BANK     = 2'd3;

endpackage

// File: rtl/mlp_sequencer_pass_timer.sv
// Per-pass wait counter: counts cycles while a PU pass settles and flags its last cycle.
module pass_timer #(
  parameter int PU_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic last
);

  logic [3:0] w;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w <= '0;
    end else if (clr) begin
      w <= '0;
    end else begin
      w <= w + 4'd1;
    end
  end

  assign last = (w == 4'(PU_LAT - 1));

endmodule

// File: rtl/mlp_sequencer.sv
// Inference sequencer: fetch, three hidden passes, one output pass, check, advance.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | read sample and label
// HID   | hidden pass p settling; load hidden regs on its last cycle
// OUT   | output pass settling; load output reg on its last cycle
// CHECK | compare argmax with label, bump accuracy
// NEXT  | advance sample address, stop after the last sample
// DONE  | run finished, hold until reset
module mlp_sequencer
  import mlp_pkg::*;
#(
  parameter int NUM_SAMPLES = 750,
  parameter int PU_LAT      = 2,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              eql,
  input  logic [ADDR_W-1:0] addr_count,
  output logic              mem_read,
  output logic              label_mem_read,
  output logic              input_sel,
  output logic              reg_sel,
  output logic [1:0]        weight_sel,
  output logic [1:0]        bias_sel,
  output logic [29:0]       reg_load,
  output logic              out_load,
  output logic              addr_count_enable,
  output logic              ac_count_enable,
  output logic              busy,
  output logic              done
);

  state_t     state;
  logic [1:0] p;
  logic       last;
  logic       timer_clr;

  // The timer only runs inside a pass and restarts at every pass boundary.
  assign timer_clr = !((state == HID) || (state == OUT)) || last;

  pass_timer #(.PU_LAT(PU_LAT)) u_pass_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .last (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      p     <= '0;
    end else begin
      case (state)
        IDLE:  if (start) state <= FETCH;
        FETCH: begin
          state <= HID;
          p     <= '0;
        end
        HID: begin
          if (last) begin
            if (p == 2'(HID_PASSES - 1)) begin
              state <= OUT;
              p     <= '0;
            end else begin
              p <= p + 2'd1;
            end
          end
        end
        OUT:   if (last) state <= CHECK;
        CHECK: state <= NEXT;
        NEXT:  state <= (addr_count == ADDR_W'(NUM_SAMPLES - 1)) ? DONE : FETCH;
        DONE:  state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_read          = 1'b0;
    label_mem_read    = 1'b0;
    input_sel         = 1'b0;
    reg_sel           = 1'b0;
    weight_sel        = 2'd0;
    bias_sel          = 2'd0;
    reg_load          = '0;
    out_load          = 1'b0;
    addr_count_enable = 1'b0;
    ac_count_enable   = 1'b0;
    done              = 1'b0;
    case (state)
      FETCH: begin
        mem_read       = 1'b1;
        label_mem_read = 1'b1;
      end
      HID: begin
        mem_read   = 1'b1;
        weight_sel = p;
        bias_sel   = p;
        if (last) reg_load = 30'h3ff << (PUS_PER_PASS * int'(p));
      end
      OUT: begin
        mem_read   = 1'b1;
        input_sel  = 1'b1;
        reg_sel    = 1'b1;
        weight_sel = OUT_BANK;
        bias_sel   = OUT_BANK;
        out_load   = last;
      end
      CHECK: begin
        label_mem_read  = 1'b1;
        reg_sel         = 1'b1;
        ac_count_enable = eql;
      end
      NEXT:    addr_count_enable = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
    busy = (state != IDLE) && (state != DONE);
  end

endmodule
